// File: rtl/main_mem_responder.sv
// Line-oriented main-memory model answering cache refills and write-backs after a fixed latency.
// Optional completed-transfer counters are built when MAIN_MEM_STAT_EN is defined.
module main_mem_responder #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int MEM_ADDR_LEN  = 12,
  parameter int LATENCY       = 4
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    req_valid,
  output logic                                    req_ready,
  input  logic                                    req_we,
  input  logic [MEM_ADDR_LEN-LINE_ADDR_LEN-1:0]   req_line_addr,
  input  logic                                    wr_word_valid,
  input  logic [31:0]                             wr_word_data,
  output logic                                    wr_word_ready,
  output logic                                    wr_done,
  output logic                                    rd_word_valid,
  output logic [31:0]                             rd_word_data,
  output logic                                    rd_word_last,
  output logic                                    busy,
  output logic [31:0]                             rd_count,
  output logic [31:0]                             wr_count
);

  localparam int TAG_W  = MEM_ADDR_LEN - LINE_ADDR_LEN;
  localparam int WAIT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [WAIT_W-1:0]        WAIT_LAST = (LATENCY > 0) ? WAIT_W'(LATENCY - 1) : {WAIT_W{1'b0}};
  localparam logic [WAIT_W-1:0]        WAIT_ONE  = WAIT_W'(32'd1);
  localparam logic [LINE_ADDR_LEN-1:0] OFF_LAST  = {LINE_ADDR_LEN{1'b1}};
  localparam logic [LINE_ADDR_LEN-1:0] OFF_ONE   = LINE_ADDR_LEN'(32'd1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RD   = 2'd2,
    ST_WR   = 2'd3
  } state_t;

  state_t                   state_r;
  state_t                   state_s;
  logic [TAG_W-1:0]         line_r;
  logic                     we_r;
  logic [LINE_ADDR_LEN-1:0] off_r;
  logic [WAIT_W-1:0]        wait_r;
  logic                     wr_done_r;
  logic [31:0]              mem_r [0:(1<<MEM_ADDR_LEN)-1];

  logic                     accept_s;
  logic                     wr_beat_s;
  logic                     wr_final_s;
  logic                     rd_final_s;
  logic [MEM_ADDR_LEN-1:0]  word_addr_s;

  assign accept_s    = (state_r == ST_IDLE) && req_valid;
  assign wr_beat_s   = (state_r == ST_WR) && wr_word_valid;
  assign wr_final_s  = wr_beat_s && (off_r == OFF_LAST);
  assign rd_final_s  = (state_r == ST_RD) && (off_r == OFF_LAST);
  assign word_addr_s = {line_r, off_r};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; a zero latency skips WAIT using the live req_we
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (LATENCY > 0) begin
            state_s = ST_WAIT;
          end else begin
            state_s = req_we ? ST_WR : ST_RD;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (wait_r == WAIT_LAST) begin
          state_s = we_r ? ST_WR : ST_RD;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_RD: begin
        if (rd_final_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RD;
        end
      end
      ST_WR: begin
        if (wr_final_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_WR;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Request latch, latency timer, burst offset and the write-done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      line_r    <= {TAG_W{1'b0}};
      we_r      <= 1'b0;
      off_r     <= {LINE_ADDR_LEN{1'b0}};
      wait_r    <= {WAIT_W{1'b0}};
      wr_done_r <= 1'b0;
    end else begin
      wr_done_r <= wr_final_s;
      if (accept_s) begin
        line_r <= req_line_addr;
        we_r   <= req_we;
        off_r  <= {LINE_ADDR_LEN{1'b0}};
        wait_r <= {WAIT_W{1'b0}};
      end else if (state_r == ST_WAIT) begin
        wait_r <= wait_r + WAIT_ONE;
      end else if (((state_r == ST_RD) && !rd_final_s) || (wr_beat_s && !wr_final_s)) begin
        // Offset holds on the final beat so it never wraps inside a burst
        off_r <= off_r + OFF_ONE;
      end
    end
  end

  // Storage array; reset leaves contents untouched
  always_ff @(posedge clk) begin
    if (wr_beat_s && !rst) begin
      mem_r[word_addr_s] <= wr_word_data;
    end
  end

  // Output decode from the registered state
  always_comb begin
    req_ready     = 1'b0;
    rd_word_valid = 1'b0;
    rd_word_last  = 1'b0;
    wr_word_ready = 1'b0;
    rd_word_data  = 32'd0;
    case (state_r)
      ST_IDLE: req_ready = 1'b1;
      ST_WAIT: req_ready = 1'b0;
      ST_RD: begin
        rd_word_valid = 1'b1;
        rd_word_last  = rd_final_s;
        rd_word_data  = mem_r[word_addr_s];
      end
      ST_WR:   wr_word_ready = 1'b1;
      default: req_ready = 1'b0;
    endcase
    busy    = !req_ready;
    // The completion pulse lands on the first IDLE cycle, alongside req_ready
    wr_done = wr_done_r;
  end

`ifdef MAIN_MEM_STAT_EN
  logic [31:0] rd_count_r;
  logic [31:0] wr_count_r;

  // Completed-transfer counters, wrapping modulo 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count_r <= 32'd0;
      wr_count_r <= 32'd0;
    end else begin
      if (rd_final_s) begin
        rd_count_r <= rd_count_r + 32'd1;
      end
      if (wr_final_s) begin
        wr_count_r <= wr_count_r + 32'd1;
      end
    end
  end

  assign rd_count = rd_count_r;
  assign wr_count = wr_count_r;
`else
  assign rd_count = 32'd0;
  assign wr_count = 32'd0;
`endif

endmodule

// File: tb/tb_main_mem_responder.sv
// Randomized self-checking bench for main_mem_responder against a line-level memory model.
module tb_main_mem_responder;

  localparam int LATENCY = 4;
  localparam int TAG_W   = 9;
`ifdef MAIN_MEM_STAT_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [TAG_W-1:0]  req_line_addr;
  logic              wr_word_valid;
  logic [31:0]       wr_word_data;
  logic              wr_word_ready;
  logic              wr_done;
  logic              rd_word_valid;
  logic [31:0]       rd_word_data;
  logic              rd_word_last;
  logic              busy;
  logic [31:0]       rd_count;
  logic [31:0]       wr_count;

  main_mem_responder #(.LINE_ADDR_LEN(3), .MEM_ADDR_LEN(12), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_line_addr(req_line_addr),
    .wr_word_valid(wr_word_valid), .wr_word_data(wr_word_data),
    .wr_word_ready(wr_word_ready), .wr_done(wr_done),
    .rd_word_valid(rd_word_valid), .rd_word_data(rd_word_data), .rd_word_last(rd_word_last),
    .busy(busy), .rd_count(rd_count), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  // Model: memory image, completed-transfer tallies, staging buffer for a write-back line
  logic [31:0] ref_mem [0:4095];
  logic [31:0] wbuf [0:7];
  int unsigned exp_rd = 0;
  int unsigned exp_wr = 0;
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_counts();
    check_eq("rd_count", rd_count, STAT ? exp_rd : 32'd0);
    check_eq("wr_count", wr_count, STAT ? exp_wr : 32'd0);
  endtask

  task automatic check_idle_outputs();
    check_eq("idle_ready", 32'(req_ready), 32'd1);
    check_eq("idle_busy", 32'(busy), 32'd0);
    check_eq("idle_rvalid", 32'(rd_word_valid), 32'd0);
    check_eq("idle_rlast", 32'(rd_word_last), 32'd0);
    check_eq("idle_rdata", rd_word_data, 32'd0);
    check_eq("idle_wready", 32'(wr_word_ready), 32'd0);
    check_eq("idle_wdone", 32'(wr_done), 32'd0);
  endtask

  task automatic accept(input logic [TAG_W-1:0] line, input logic we);
    req_valid = 1'b1;
    req_we = we;
    req_line_addr = line;
    check_eq("req_ready", 32'(req_ready), 32'd1);
    step();
  endtask

  // Count cycles from acceptance until the burst-side strobe shows up
  task automatic wait_burst(input bit is_wr);
    int cnt = 0;
    while (((is_wr ? wr_word_ready : rd_word_valid) == 1'b0) && cnt < 64) begin
      check_eq("wait_busy", 32'(busy), 32'd1);
      check_eq("wait_rdata", rd_word_data, 32'd0);
      step();
      cnt++;
    end
    check_eq(is_wr ? "wr_latency" : "rd_latency", cnt, LATENCY);
  endtask

  task automatic rd_line(input logic [TAG_W-1:0] line, input bit hold, input logic [TAG_W-1:0] hold_line);
    accept(line, 1'b0);
    if (hold) begin
      req_valid = 1'b1;
      req_line_addr = hold_line;
    end else begin
      req_valid = 1'b0;
      req_line_addr = TAG_W'($urandom);
    end
    wait_burst(1'b0);
    for (int k = 0; k < 8; k++) begin
      check_eq("rd_valid", 32'(rd_word_valid), 32'd1);
      check_eq("rd_data", rd_word_data, ref_mem[{line, k[2:0]}]);
      check_eq("rd_last", 32'(rd_word_last), (k == 7) ? 32'd1 : 32'd0);
      step();
    end
    exp_rd++;
    check_eq("rd_end_valid", 32'(rd_word_valid), 32'd0);
    check_eq("rd_end_data", rd_word_data, 32'd0);
    check_eq("rd_end_ready", 32'(req_ready), 32'd1);
    check_counts();
  endtask

  task automatic wr_line(input logic [TAG_W-1:0] line, input int gap_at, input int gap_len, input bit rnd_gaps);
    int g;
    accept(line, 1'b1);
    req_valid = 1'b0;
    req_we = 1'($urandom);
    req_line_addr = TAG_W'($urandom);
    wait_burst(1'b1);
    for (int i = 0; i < 8; i++) begin
      g = (i == gap_at) ? gap_len : 0;
      if (rnd_gaps && $urandom_range(0, 3) == 0) g += $urandom_range(1, 3);
      for (int j = 0; j < g; j++) begin
        wr_word_valid = 1'b0;
        wr_word_data = $urandom;
        step();
        check_eq("gap_wready", 32'(wr_word_ready), 32'd1);
        check_eq("gap_wdone", 32'(wr_done), 32'd0);
      end
      wr_word_valid = 1'b1;
      wr_word_data = wbuf[i];
      step();
      ref_mem[{line, i[2:0]}] = wbuf[i];
      if (i < 7) begin
        check_eq("wr_mid_done", 32'(wr_done), 32'd0);
        check_eq("wr_mid_ready", 32'(wr_word_ready), 32'd1);
      end else begin
        exp_wr++;
        check_eq("wr_done", 32'(wr_done), 32'd1);
        check_eq("wr_done_reqrdy", 32'(req_ready), 32'd1);
        check_eq("wr_done_wready", 32'(wr_word_ready), 32'd0);
      end
    end
    wr_word_valid = 1'b0;
    wr_word_data = $urandom;
    step();
    check_eq("wr_done_once", 32'(wr_done), 32'd0);
    check_counts();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_rd = 0;
    exp_wr = 0;
  endtask

  task automatic rd_abort(input logic [TAG_W-1:0] line, input int beat);
    accept(line, 1'b0);
    req_valid = 1'b0;
    wait_burst(1'b0);
    for (int k = 0; k < beat; k++) begin
      check_eq("ab_rd_data", rd_word_data, ref_mem[{line, k[2:0]}]);
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_rd = 0;
    exp_wr = 0;
    check_idle_outputs();
    check_counts();
  endtask

  task automatic wr_abort(input logic [TAG_W-1:0] line, input int nwords);
    accept(line, 1'b1);
    req_valid = 1'b0;
    wait_burst(1'b1);
    for (int i = 0; i < nwords; i++) begin
      wr_word_valid = 1'b1;
      wr_word_data = wbuf[i];
      step();
      ref_mem[{line, i[2:0]}] = wbuf[i];
    end
    wr_word_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_rd = 0;
    exp_wr = 0;
    check_idle_outputs();
    check_counts();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [TAG_W-1:0] rline;
    rst = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_line_addr = '0;
    wr_word_valid = 1'b0;
    wr_word_data = 32'd0;
    step();
    step();
    rst = 1'b0;
    check_idle_outputs();
    check_counts();

    // Write-back line 5 with 0xA0..0xA7, then refill it
    for (int i = 0; i < 8; i++) wbuf[i] = 32'hA0 + i;
    wr_line(9'd5, -1, 0, 1'b0);
    rd_line(9'd5, 1'b0, 9'd0);

    // Three idle cycles between words 2 and 3
    for (int i = 0; i < 8; i++) wbuf[i] = $urandom;
    wr_line(9'd9, 3, 3, 1'b0);
    rd_line(9'd9, 1'b0, 9'd0);

    // Random lines, random data, random gaps
    for (int t = 0; t < 6; t++) begin
      rline = TAG_W'($urandom_range(10, 511));
      for (int i = 0; i < 8; i++) wbuf[i] = $urandom;
      wr_line(rline, -1, 0, 1'b1);
      rd_line(rline, 1'b0, 9'd0);
      if ($urandom_range(0, 1) == 1) rd_line(9'd5, 1'b0, 9'd0);
    end

    // A request held during a busy refill is ignored, then taken on the first IDLE cycle
    rd_line(9'd5, 1'b1, 9'd9);
    rd_line(9'd9, 1'b0, 9'd0);

    // Reset at refill beat 3, immediate new request, contents intact
    rd_abort(9'd9, 3);
    rd_line(9'd9, 1'b0, 9'd0);
    rd_line(9'd5, 1'b0, 9'd0);

    // Reset after three write words keeps those three
    for (int i = 0; i < 8; i++) wbuf[i] = $urandom;
    wr_abort(9'd5, 3);
    rd_line(9'd5, 1'b0, 9'd0);

    // Two refills and one write-back since the last reset
    for (int i = 0; i < 8; i++) wbuf[i] = $urandom;
    wr_line(9'd9, -1, 0, 1'b1);
    rd_line(9'd9, 1'b0, 9'd0);
    check_eq("final_rd_count", rd_count, STAT ? 32'd2 : 32'd0);
    check_eq("final_wr_count", wr_count, STAT ? 32'd1 : 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/main_mem_responder.md
MAIN_MEM_RESPONDER -- requirements
Module: main_mem_responder

Interface
- REQ-001 SHALL have parameter LINE_ADDR_LEN, default 3; log2 of 32-bit words per cache line (8 words).
- REQ-002 SHALL have parameter MEM_ADDR_LEN, default 12; log2 of total 32-bit words stored.
- REQ-003 SHALL have parameter LATENCY, default 4; cycles between request acceptance and the first burst beat.
- REQ-004 SHALL use one clock and a synchronous, active-high reset, as follows:
  - clk  input  1  rising-edge clock.
  - rst  input  1  synchronous active-high reset.
- REQ-005 SHALL have the following request ports:
  - req_valid  input  1  cache requests a line transfer.
  - req_ready  output  1  responder can accept a request.
  - req_we  input  1  1 = line write-back, 0 = line refill.
  - req_line_addr  input  MEM_ADDR_LEN-LINE_ADDR_LEN  line address.
- REQ-006 SHALL have the following write-data ports:
  - wr_word_valid  input  1  write-back word present.
  - wr_word_data  input  32  write-back word.
  - wr_word_ready  output  1  responder accepts a write word.
  - wr_done  output  1  one-cycle pulse when the write-back completes.
- REQ-007 SHALL have the following read-data ports:
  - rd_word_valid  output  1  refill word present (the cache always accepts it).
  - rd_word_data  output  32  refill word.
  - rd_word_last  output  1  marks the final refill word.
- REQ-008 SHALL have the following status ports:
  - busy  output  1  high in every state other than IDLE.
  - rd_count  output  32  completed refills.
  - wr_count  output  32  completed write-backs.

Function
- REQ-009 SHALL hold an internal array of 2^MEM_ADDR_LEN 32-bit words; word address = {line_addr, offset}.
- REQ-010 SHALL implement states IDLE, WAIT, RD_BURST, WR_BURST; req_ready = 1 only in IDLE.
- REQ-011 SHALL accept a request when req_valid && req_ready at a rising edge, latching req_we and req_line_addr; later changes to the req_* inputs are ignored until return to IDLE.
- REQ-012 SHALL, on acceptance with LATENCY>0, enter WAIT and remain there exactly LATENCY cycles, then enter RD_BURST (req_we=0) or WR_BURST (req_we=1).
- REQ-013 SHALL, when LATENCY=0, enter the burst state directly on the cycle after acceptance.
- REQ-014 RD_BURST SHALL assert rd_word_valid for 2^LINE_ADDR_LEN consecutive cycles, with no gaps and no backpressure.
- REQ-015 In RD_BURST, beat k SHALL carry mem[{line,k}] with k ascending from 0, and rd_word_last SHALL be high only on beat 2^LINE_ADDR_LEN-1.
- REQ-016 SHALL return to IDLE (req_ready=1) on the cycle after the last refill beat.
- REQ-017 WR_BURST SHALL hold wr_word_ready = 1.
- REQ-018 In WR_BURST, each cycle with wr_word_valid SHALL write wr_word_data to mem[{line,offset}] and then increment offset; cycles with wr_word_valid=0 SHALL insert gaps with no write and no offset change.
- REQ-019 SHALL, after the 2^LINE_ADDR_LEN-th accepted write word, pulse wr_done for one cycle, drop wr_word_ready, and return to IDLE in that same cycle.
- REQ-020 A write-back followed by a refill of the same line SHALL return the newly written data.
- REQ-021 The offset counter SHALL be LINE_ADDR_LEN bits wide, reset to 0 at each request acceptance, and SHALL never wrap within a burst.
- REQ-022 rd_word_valid, rd_word_last, wr_word_ready and wr_done SHALL be 0 in IDLE and WAIT; rd_word_data SHALL be 0 when rd_word_valid=0.
- REQ-023 req_valid while busy=1 SHALL be ignored, with no queueing.

Reset
- REQ-024 rst SHALL force IDLE, offset 0, req_ready=1, busy=0, and rd_word_valid/rd_word_last/wr_word_ready/wr_done/rd_word_data = 0 on the next edge.
- REQ-025 rst asserted mid-burst or mid-WAIT SHALL abort the transfer without emitting wr_done or rd_word_last; words already written stay written.
- REQ-026 rst SHALL NOT clear the memory array.
- REQ-027 rst SHALL clear rd_count and wr_count to 0.

Configuration
- REQ-028 Macro MAIN_MEM_STAT_EN defined: rd_count increments on the cycle of rd_word_last, and wr_count increments on the cycle of wr_done; both wrap modulo 2^32.
- REQ-029 Macro MAIN_MEM_STAT_EN undefined: rd_count and wr_count are tied to 0, no counter flops exist, and all other behaviour is identical.

Verification
- REQ-030 Reset, then write-back line 5 with words 0xA0..0xA7 and no gaps -> wr_word_ready rises 4 cycles after acceptance; wr_done pulses once after the 8th word; req_ready=1 in the same cycle.
- REQ-031 Refill line 5 -> rd_word_valid rises 4 cycles after acceptance; beats 0xA0..0xA7 in order; rd_word_last only on 0xA7; IDLE the next cycle.
- REQ-032 Write-back with wr_word_valid low for 3 cycles between words 2 and 3 -> no spurious writes; a refill returns the exact 8 words.
- REQ-033 Pulse rst at beat 3 of a refill -> outputs 0 on the next edge with no rd_word_last; a new request is accepted immediately and the memory contents are intact.
- REQ-034 Hold req_valid high with a different line address during busy -> the request is ignored and the latched address is unchanged; the held request is accepted on the first IDLE cycle.
- REQ-035 With MAIN_MEM_STAT_EN, run 2 refills and 1 write-back -> rd_count=2, wr_count=1; without the macro both stay 0.
